// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite single-port SRAM slave with configurable depth and NONSEQ wait
//   states. SEQ beats complete with zero wait. Byte and halfword writes are
//   strobed from HSIZE/HADDR[1:0]. A read whose address phase lines up with
//   the DATA cycle of a write to the same word sees the merged new word.
//
// Optional feature macro: AHB_SRAM_ERR_EN
//   defined   : out-of-range, oversize and misaligned transfers get a
//               two-cycle ERROR response and never touch the memory.
//   undefined : the word index wraps, HSIZE>2 acts as a word access, low
//               address bits are ignored, and HRESP is tied to OKAY.
//
// Parameters
//   MEM_DEPTH   memory size in 32-bit words (power of two, 16..65536)
//   ADDR_BITS   HADDR bits decoded as a byte offset
//   WAIT_STATES HREADYOUT-low cycles at the start of a NONSEQ data phase (0..7)
//
// Ports
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,      address-phase controls from the master/decoder
//   HWRITE, HSIZE, HBURST
//   HWDATA                    write data (data phase)
//   HREADY                    bus-level ready (gates address acceptance)
//   HREADYOUT, HRESP, HRDATA  slave response back to the bus mux

module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 4096,
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int FULL_W = ADDR_BITS - 2;

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

  state_t state, state_next;

  logic [2:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic             seq_q;
  logic [31:0]      rdata_q;

  logic [31:0] mem [MEM_DEPTH];

  logic              accept;
  logic [FULL_W-1:0] full_idx;
  logic [IDX_W-1:0]  addr_idx;
  logic              illegal;
  logic [3:0]        strb;
  logic [31:0]       merged;
  logic              commit;
  logic              load_rd;
  logic [IDX_W-1:0]  load_idx;
  logic [31:0]       rd_word;

  // HBURST is deliberately ignored, the captured SEQ flag is kept only for
  // visibility, and address bits above the decoded range carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HADDR, seq_q, full_idx};

  assign accept   = HSEL & HTRANS[1] & HREADY;
  assign full_idx = HADDR[ADDR_BITS-1:2];
  assign addr_idx = full_idx[IDX_W-1:0];

`ifdef AHB_SRAM_ERR_EN
  assign illegal = (32'(full_idx) >= 32'(MEM_DEPTH))
                 | (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (|HADDR[1:0]));
`else
  assign illegal = 1'b0;
`endif

  // Next-state logic. IDLE, DATA and ERR2 are all cycles where HREADYOUT is
  // high, so each of them can accept and pipeline the next address phase.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: begin
        if (wait_cnt == 3'd0) state_next = S_DATA;
      end
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: state_next = S_ERR2;
`endif
      default: begin
        state_next = S_IDLE;
        if (accept) begin
`ifdef AHB_SRAM_ERR_EN
          if (illegal) state_next = S_ERR1;
          else
`endif
          if (!HTRANS[0] && (WAIT_STATES > 0)) state_next = S_WAIT;
          else state_next = S_DATA;
        end
      end
    endcase
  end

  // Byte-lane strobes for the write currently in its data phase; any size
  // above halfword (including the illegal ones in the wrapping build) is a
  // full word.
  always_comb begin
    strb = 4'b0000;
    case (size_q)
      3'd0: strb[lane_q] = 1'b1;
      3'd1: begin
        strb[{lane_q[1], 1'b0}] = 1'b1;
        strb[{lane_q[1], 1'b1}] = 1'b1;
      end
      default: strb = 4'b1111;
    endcase
  end

  // Word as it will look after this cycle's write commits.
  always_comb begin
    merged = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  assign commit = (state == S_DATA) & write_q & ~illegal_q_unused();

  // Read data is loaded on the edge that enters DATA: from the live address
  // for a zero-wait entry, from the captured index when leaving WAIT.
  always_comb begin
    load_rd  = 1'b0;
    load_idx = idx_q;
    if (state_next == S_DATA) begin
      if (state == S_WAIT) begin
        load_rd  = ~write_q;
        load_idx = idx_q;
      end else begin
        load_rd  = ~HWRITE;
        load_idx = addr_idx;
      end
    end
  end

  // A write committing on the same edge wins over the stale array contents.
  assign rd_word = (commit && (load_idx == idx_q)) ? merged : mem[load_idx];

  function automatic logic illegal_q_unused();
    return 1'b0;
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_next;
  end

  // Wait counter is loaded with WAIT_STATES-1 on entry so WAIT lasts exactly
  // WAIT_STATES cycles.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= 3'd0;
    end else if ((state_next == S_WAIT) && (state != S_WAIT)) begin
      wait_cnt <= 3'(WAIT_STATES - 1);
    end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Address-phase capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      seq_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= addr_idx;
      lane_q  <= HADDR[1:0];
      size_q  <= HSIZE;
      write_q <= HWRITE;
      seq_q   <= HTRANS[0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     rdata_q <= 32'd0;
    else if (load_rd) rdata_q <= rd_word;
  end

  // Storage has no reset; an aborted write never reaches DATA, so it never
  // commits.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SRAM_ERR_EN
  assign HREADYOUT = ~((state == S_WAIT) | (state == S_ERR1));
  assign HRESP     = ((state == S_ERR1) | (state == S_ERR2)) ? 2'b01 : 2'b00;
`else
  assign HREADYOUT = (state != S_WAIT);
  assign HRESP     = 2'b00;
`endif
  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Drives pipelined AHB-Lite transfers into ahb_sram_slave. Every accepted
//   transfer pushes its expected response (computed from a word-array model)
//   into a queue; a monitor pops and compares on each completed data phase.

module tb_ahb_sram_slave;

  localparam int DEPTH = 4096;
  localparam int ABITS = 16;
  localparam int W     = 2;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = 32'd0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd0;
  logic [2:0]  HBURST  = 3'd0;
  logic [31:0] HWDATA  = 32'd0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(
    .MEM_DEPTH  (DEPTH),
    .ADDR_BITS  (ABITS),
    .WAIT_STATES(W)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA)
  );

  typedef struct {
    bit          is_read;
    bit          is_err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: a sparse array of 32-bit words plus the legality rules.
  function automatic bit is_error(input logic [31:0] addr, input logic [2:0] size);
    int unsigned off;
    off = addr % (32'd1 << ABITS);
    if (!ERR_EN) return 1'b0;
    if (off / 4 >= DEPTH) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && (off % 2) != 0) return 1'b1;
    if (size == 3'd2 && (off % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_index(input logic [31:0] addr);
    int unsigned off;
    off = addr % (32'd1 << ABITS);
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic bit lane_hit(input logic [31:0] addr, input logic [2:0] size, input int lane);
    int low;
    low = int'(addr % 4);
    if (size == 3'd0) return lane == low;
    if (size == 3'd1) return (lane / 2) == (low / 2);
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    logic [31:0] word;
    int          idx;
    idx  = word_index(addr);
    word = model_read(idx);
    for (int l = 0; l < 4; l++) begin
      if (lane_hit(addr, size, l)) word[8*l +: 8] = data[8*l +: 8];
    end
    ref_mem[idx] = word;
  endtask

  // Offers one address phase, waits (bounded) for it to be accepted, then
  // places write data on the bus for its data phase and records the
  // expected response.
  task automatic applyStimulus(input logic [31:0] addr, input bit write, input logic [2:0] size,
                               input bit seq, input logic [31:0] wdata);
    exp_t e;
    int   n;
    bit   rdy;
    HSEL   = 1'b1;
    HADDR  = addr;
    HTRANS = seq ? 2'b11 : 2'b10;
    HWRITE = write;
    HSIZE  = size;
    HBURST = seq ? 3'b011 : 3'b001;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 64) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got no HREADY for 0x%08h, expected acceptance", addr);
      return;
    end
    HWDATA    = write ? wdata : $urandom;
    e.is_err  = is_error(addr, size);
    e.is_read = !write;
    e.waits   = e.is_err ? 0 : (seq ? 0 : W);
    e.rdata   = model_read(word_index(addr));
    if (write && !e.is_err) model_write(addr, size, wdata);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    int n;
    bit rdy;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 64) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_timeout: got HREADYOUT stuck low, expected 1");
    end
  endtask

  // Monitor: tracks data phases from the bus itself and scores each
  // completion against the head of the expectation queue.
  bit   data_active = 1'b0;
  int   wait_low    = 0;
  int   err_low     = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        data_active = 1'b0;
        exp_q.delete();
      end else begin
        if (data_active) begin
          if (!HREADYOUT) begin
            if (HRESP == 2'b01) err_low++;
            else wait_low++;
          end else begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL unexpected_completion: got a data phase, expected none");
            end else begin
              mon_e = exp_q.pop_front();
              checkOutput("hresp", 32'(HRESP), mon_e.is_err ? 32'd1 : 32'd0);
              checkOutput("wait_cycles", 32'(wait_low), 32'(mon_e.waits));
              checkOutput("err1_cycles", 32'(err_low), mon_e.is_err ? 32'd1 : 32'd0);
              if (mon_e.is_read && !mon_e.is_err) checkOutput("hrdata", HRDATA, mon_e.rdata);
            end
            data_active = 1'b0;
          end
        end
        if (HSEL && HTRANS[1] && HREADYOUT) begin
          data_active = 1'b1;
          wait_low    = 0;
          err_low     = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $finish;
  end

  initial begin
    logic [31:0] saved;
    logic [31:0] a;
    logic [2:0]  sz;
    bit          wr;
    bit          sq;
    int          n;

    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("reset_hreadyout", 32'(HREADYOUT), 32'd1);
    checkOutput("reset_hresp", 32'(HRESP), 32'd0);
    checkOutput("reset_hrdata", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Wait-state read
    applyStimulus(32'h0040, 1, 3'd2, 0, 32'h12345678);
    applyStimulus(32'h0040, 0, 3'd2, 0, 32'h0);
    idle_cycle();

    // Byte and halfword strobes
    applyStimulus(32'h0100, 1, 3'd2, 0, 32'h00000000);
    applyStimulus(32'h0101, 1, 3'd0, 0, 32'h0000AB00);
    applyStimulus(32'h0102, 1, 3'd1, 0, 32'hCDEF0000);
    applyStimulus(32'h0100, 0, 3'd2, 0, 32'h0);
    idle_cycle();

    // Zero-wait SEQ bursts
    for (int i = 0; i < 4; i++) applyStimulus(32'h0200 + 32'(4*i), 1, 3'd2, i != 0, 32'(i + 1));
    for (int i = 0; i < 4; i++) applyStimulus(32'h0200 + 32'(4*i), 0, 3'd2, i != 0, 32'h0);
    idle_cycle();

    // Forwarding: NONSEQ read after write, and a zero-wait read on the
    // commit edge
    applyStimulus(32'h0300, 1, 3'd2, 0, 32'hDEADBEEF);
    applyStimulus(32'h0300, 0, 3'd2, 0, 32'h0);
    applyStimulus(32'h0304, 1, 3'd2, 0, 32'h0BADF00D);
    applyStimulus(32'h0304, 0, 3'd2, 1, 32'h0);
    applyStimulus(32'h0304, 1, 3'd0, 1, 32'h00770000);
    applyStimulus(32'h0304, 0, 3'd2, 1, 32'h0);
    idle_cycle();

    // Out-of-range / oversize / misaligned transfers
    applyStimulus(32'h0000, 1, 3'd2, 0, 32'h5A5A5A5A);
    applyStimulus(32'h0008, 1, 3'd2, 0, 32'hA5A5A5A5);
    applyStimulus(32'h4000, 1, 3'd2, 0, 32'hFFFFFFFF);
    applyStimulus(32'h0000, 0, 3'd2, 0, 32'h0);
    applyStimulus(32'h0002, 0, 3'd2, 0, 32'h0);
    applyStimulus(32'h0001, 0, 3'd1, 0, 32'h0);
    applyStimulus(32'h0008, 0, 3'd3, 0, 32'h0);
    applyStimulus(32'h0000, 0, 3'd2, 1, 32'h0);
    idle_cycle();

    // Reset during the WAIT of a write
    applyStimulus(32'h0400, 1, 3'd2, 0, 32'h11111111);
    idle_cycle();
    saved = model_read(word_index(32'h0400));
    applyStimulus(32'h0400, 1, 3'd2, 0, 32'h99999999);
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HRESETn = 1'b0;
    ref_mem[word_index(32'h0400)] = saved;
    #2;
    checkOutput("midreset_hreadyout", 32'(HREADYOUT), 32'd1);
    checkOutput("midreset_hresp", 32'(HRESP), 32'd0);
    checkOutput("midreset_hrdata", HRDATA, 32'd0);
    repeat (2) @(negedge HCLK);
    #2;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    applyStimulus(32'h0400, 0, 3'd2, 0, 32'h0);
    idle_cycle();

    // Randomised traffic over a fully initialised window
    for (int i = 0; i < 32; i++) applyStimulus(32'h0800 + 32'(4*i), 1, 3'd2, (i % 8) != 0, $urandom);
    for (int i = 0; i < 200; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'h0800 + 4 * $urandom_range(0, 31);
      if (sz == 3'd0) a = a + $urandom_range(0, 3);
      else if (sz == 3'd1) a = a + 2 * $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      sq = 1'($urandom_range(0, 1));
      applyStimulus(a, wr, sz, sq, $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    n = 0;
    idle_cycle();
    while (exp_q.size() != 0 && n < 20) begin
      idle_cycle();
      n++;
    end
    checkOutput("pending_responses", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
